// File: rtl/dff_pipe_delay.sv
// Stallable register delay line: DEPTH stages of {valid, data} with flush and occupancy count.
// Optional macro DFF_PIPE_GATE_OUT_EN forces q to zero whenever out_valid is low.
module dff_pipe_delay #(
    parameter  int WIDTH = 31,
    parameter  int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic [OCC_W-1:0] occ
);

    if (DEPTH < 1) begin : g_depth_check
        $error("dff_pipe_delay: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_next_s;

    // Occupancy update: one word may enter and one may leave on the same edge
    always_comb begin
        occ_next_s = occ_r;
        if (in_valid && !valid_r[DEPTH-1]) begin
            occ_next_s = occ_r + OCC_W'(1'b1);
        end else if (!in_valid && valid_r[DEPTH-1]) begin
            occ_next_s = occ_r - OCC_W'(1'b1);
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Stage registers: async reset, then flush over enable over hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            occ_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
        end else if (flush) begin
            // Data words are left in place; only the valid bits are cleared.
            valid_r <= '0;
            occ_r   <= '0;
        end else if (en) begin
            valid_r[0] <= in_valid;
            data_r[0]  <= d;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
            occ_r <= occ_next_s;
        end else begin
            valid_r <= valid_r;
            occ_r   <= occ_r;
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign occ       = occ_r;

`ifdef DFF_PIPE_GATE_OUT_EN
    assign q = data_r[DEPTH-1] & {WIDTH{valid_r[DEPTH-1]}};
`else
    assign q = data_r[DEPTH-1];
`endif

endmodule
